// File: rtl/diff_calc.sv
// diff_calc: front end for the neck (constriction) judge.
// Block-averages arc resistance samples over 2**AVG_LOG2 samples, keeps the
// last four averages and produces saturated 1st/2nd/3rd backward
// differences with a one-cycle en_judge strobe.
// Ports:
//   clk               system clock
//   rst               synchronous active-high reset
//   clear             synchronous flush (arc restart / algorithm off)
//   sample_valid      sample_data is valid this cycle
//   sample_data       signed DW-bit resistance sample
//   en_judge          one-cycle strobe: new difference set valid
//   first_order_data  d1 = a0-a1, saturated to OW bits
//   second_order_data d2 = a0-2a1+a2, saturated to OW bits
//   third_order_data  d3 = a0-3a1+3a2-a3, saturated to OW bits
//   sat               at least one difference saturated (with en_judge)
module diff_calc #(
  parameter int DW         = 12,
  parameter int OW         = 13,
  parameter int AVG_LOG2   = 2,
  parameter int GAIN_SHIFT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 sample_valid,
  input  logic signed [DW-1:0] sample_data,
  output logic                 en_judge,
  output logic signed [OW-1:0] first_order_data,
  output logic signed [OW-1:0] second_order_data,
  output logic signed [OW-1:0] third_order_data,
  output logic                 sat
);

  localparam int AW = DW + AVG_LOG2;
  localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int FW = DW + 3;
  localparam int XW = FW + GAIN_SHIFT;
  localparam logic signed [XW-1:0] SMAX = XW'((2 ** (OW - 1)) - 1);
  localparam logic signed [XW-1:0] SMIN = -SMAX - XW'(1);

  typedef enum logic {S_FILL, S_RUN} state_t;

  logic                 w_flush;
  assign w_flush = rst || clear;

  // ---------------- averaging stage ----------------
  logic signed [AW-1:0] r_acc;
  logic [CW-1:0]        r_cnt;
  logic signed [DW-1:0] r_avg;
  logic                 r_avg_v;
  logic                 w_last;
  logic signed [AW-1:0] w_sum;
  logic signed [DW-1:0] w_avg;

  assign w_last = (r_cnt == CW'((1 << AVG_LOG2) - 1));
  assign w_sum  = r_acc + AW'(sample_data);
  // floor average; a full block sum always fits AW bits, so the mean fits DW
  assign w_avg  = DW'(w_sum >>> AVG_LOG2);

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_avg   <= '0;
      r_avg_v <= 1'b0;
    end else if (sample_valid) begin
      if (w_last) begin
        r_acc   <= '0;
        r_cnt   <= '0;
        r_avg   <= w_avg;
        r_avg_v <= 1'b1;
      end else begin
        r_acc   <= w_sum;
        r_cnt   <= r_cnt + CW'(1);
        r_avg_v <= 1'b0;
      end
    end else begin
      r_avg_v <= 1'b0;
    end
  end

  // ---------------- history, fill and FSM ----------------
  logic signed [DW-1:0] r_hist [4];
  logic [2:0]           r_fill;
  logic                 r_shift_v;
  state_t               r_state;
  state_t               w_state_nx;
  logic                 w_strobe;

  always_ff @(posedge clk) begin
    if (w_flush) begin
      r_state <= S_FILL;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_strobe   = 1'b0;
    case (r_state)
      S_FILL: if (r_avg_v && (r_fill == 3'd3)) w_state_nx = S_RUN;
      S_RUN:  w_strobe = r_shift_v;
      default: w_state_nx = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_flush) begin
      for (int unsigned i = 0; i < 4; i++) r_hist[i] <= '0;
      r_fill    <= '0;
      r_shift_v <= 1'b0;
    end else begin
      r_shift_v <= r_avg_v;
      if (r_avg_v) begin
        r_hist[3] <= r_hist[2];
        r_hist[2] <= r_hist[1];
        r_hist[1] <= r_hist[0];
        r_hist[0] <= r_avg;
        if (r_fill != 3'd4) r_fill <= r_fill + 3'd1;
      end
    end
  end

  // ---------------- difference stage ----------------
  logic signed [FW-1:0] w_h0, w_h1, w_h2, w_h3;
  logic signed [FW-1:0] w_d1, w_d2, w_d3;
  logic signed [XW-1:0] w_x1, w_x2, w_x3;
  logic [OW:0]          w_s1, w_s2, w_s3;

  assign w_h0 = FW'(r_hist[0]);
  assign w_h1 = FW'(r_hist[1]);
  assign w_h2 = FW'(r_hist[2]);
  assign w_h3 = FW'(r_hist[3]);

  assign w_d1 = w_h0 - w_h1;
  assign w_d2 = w_h0 - (w_h1 <<< 1) + w_h2;
  assign w_d3 = w_h0 - ((w_h1 <<< 1) + w_h1) + ((w_h2 <<< 1) + w_h2) - w_h3;

  assign w_x1 = XW'(w_d1) <<< GAIN_SHIFT;
  assign w_x2 = XW'(w_d2) <<< GAIN_SHIFT;
  assign w_x3 = XW'(w_d3) <<< GAIN_SHIFT;

  // returns {saturated flag, clamped value}
  function automatic logic [OW:0] f_sat(input logic signed [XW-1:0] v);
    if (v > SMAX)      return {1'b1, SMAX[OW-1:0]};
    else if (v < SMIN) return {1'b1, SMIN[OW-1:0]};
    else               return {1'b0, v[OW-1:0]};
  endfunction

  assign w_s1 = f_sat(w_x1);
  assign w_s2 = f_sat(w_x2);
  assign w_s3 = f_sat(w_x3);

  always_ff @(posedge clk) begin
    if (w_flush) begin
      en_judge          <= 1'b0;
      first_order_data  <= '0;
      second_order_data <= '0;
      third_order_data  <= '0;
      sat               <= 1'b0;
    end else begin
      en_judge <= w_strobe;
      if (w_strobe) begin
        first_order_data  <= w_s1[OW-1:0];
        second_order_data <= w_s2[OW-1:0];
        third_order_data  <= w_s3[OW-1:0];
        sat               <= w_s1[OW] | w_s2[OW] | w_s3[OW];
      end
    end
  end

endmodule

// File: tb/tb_diff_calc.sv
// Bench for diff_calc: two instances (AVG_LOG2=2/GAIN_SHIFT=0 and
// AVG_LOG2=0/GAIN_SHIFT=1). Drivers feed a block-average reference model
// that queues expected strobes with their due cycle; a monitor compares.
module tb_diff_calc;
  localparam int DW = 12;
  localparam int OW = 13;
  localparam int OMAX = 4095;
  localparam int OMIN = -4096;

  typedef struct {
    int edge_n;
    int d1;
    int d2;
    int d3;
    bit sat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic                 rst_i [2];
  logic                 clr   [2];
  logic                 vld   [2];
  logic signed [DW-1:0] dat   [2];
  logic                 en    [2];
  logic signed [OW-1:0] o1    [2];
  logic signed [OW-1:0] o2    [2];
  logic signed [OW-1:0] o3    [2];
  logic                 st    [2];

  diff_calc #(.DW(DW), .OW(OW), .AVG_LOG2(2), .GAIN_SHIFT(0)) u_dut0 (
    .clk(clk), .rst(rst_i[0]), .clear(clr[0]), .sample_valid(vld[0]),
    .sample_data(dat[0]), .en_judge(en[0]), .first_order_data(o1[0]),
    .second_order_data(o2[0]), .third_order_data(o3[0]), .sat(st[0]));

  diff_calc #(.DW(DW), .OW(OW), .AVG_LOG2(0), .GAIN_SHIFT(1)) u_dut1 (
    .clk(clk), .rst(rst_i[1]), .clear(clr[1]), .sample_valid(vld[1]),
    .sample_data(dat[1]), .en_judge(en[1]), .first_order_data(o1[1]),
    .second_order_data(o2[1]), .third_order_data(o3[1]), .sat(st[1]));

  int nchk = 0;
  int nerr = 0;
  bit mon_on = 1'b0;

  exp_t q0[$];
  exp_t q1[$];

  // reference model state
  int msum  [2];
  int mcnt  [2];
  int mfill [2];
  int mh    [2][4];
  int lst1  [2];
  int lst2  [2];
  int lst3  [2];

  function automatic int lg(int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic int gs(int d);
    return (d == 0) ? 0 : 1;
  endfunction

  task automatic chk(string name, int act, int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic int satv(int v, output bit s);
    s = (v > OMAX) || (v < OMIN);
    if (v > OMAX) return OMAX;
    if (v < OMIN) return OMIN;
    return v;
  endfunction

  function automatic int qsize(int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qfront(int d);
    return (d == 0) ? q0[0] : q1[0];
  endfunction

  function automatic exp_t qpop(int d);
    if (d == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  task automatic model_reset(int d);
    msum[d] = 0; mcnt[d] = 0; mfill[d] = 0;
    for (int i = 0; i < 4; i++) mh[d][i] = 0;
    lst1[d] = 0; lst2[d] = 0; lst3[d] = 0;
    if (d == 0) q0.delete(); else q1.delete();
  endtask

  // one accepted sample; edge_n is the clock edge that accepts it
  task automatic model_accept(int d, int s, int edge_n);
    int a, g, r1, r2, r3;
    bit s1, s2, s3;
    exp_t e;
    msum[d] += s;
    mcnt[d]++;
    if (mcnt[d] == (1 << lg(d))) begin
      a = msum[d] >>> lg(d);
      msum[d] = 0;
      mcnt[d] = 0;
      mh[d][3] = mh[d][2]; mh[d][2] = mh[d][1]; mh[d][1] = mh[d][0]; mh[d][0] = a;
      if (mfill[d] < 4) mfill[d]++;
      if (mfill[d] == 4) begin
        g  = 1 << gs(d);
        r1 = (mh[d][0] - mh[d][1]) * g;
        r2 = (mh[d][0] - 2 * mh[d][1] + mh[d][2]) * g;
        r3 = (mh[d][0] - 3 * mh[d][1] + 3 * mh[d][2] - mh[d][3]) * g;
        e.edge_n = edge_n + 2;
        e.d1 = satv(r1, s1);
        e.d2 = satv(r2, s2);
        e.d3 = satv(r3, s3);
        e.sat = s1 | s2 | s3;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
      end
    end
  endtask

  // drive one cycle
  task automatic step(int d, bit v, int s);
    @(negedge clk); #1;
    vld[d] = v;
    dat[d] = 12'(s);
    if (v) model_accept(d, s, cyc + 1);
  endtask

  task automatic idle(int d, int n);
    repeat (n) step(d, 1'b0, 0);
  endtask

  // rst or clear pulse, optionally with a coincident (to be dropped) sample
  task automatic flush(int d, bit use_rst, bit v, int s);
    @(negedge clk); #1;
    if (use_rst) rst_i[d] = 1'b1; else clr[d] = 1'b1;
    vld[d] = v;
    dat[d] = 12'(s);
    model_reset(d);
    @(negedge clk); #1;
    rst_i[d] = 1'b0; clr[d] = 1'b0; vld[d] = 1'b0;
    chk("flush_en", int'(en[d]), 0);
    chk("flush_d1", int'(o1[d]), 0);
    chk("flush_d3", int'(o3[d]), 0);
    chk("flush_sat", int'(st[d]), 0);
  endtask

  function automatic int rnd_sample();
    int r;
    r = int'($urandom_range(15, 0));
    if (r == 0) return -2048;
    if (r == 1) return 2047;
    return int'($urandom_range(4095, 0)) - 2048;
  endfunction

  // monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (mon_on) begin
      for (int d = 0; d < 2; d++) begin
        if (en[d]) begin
          if (qsize(d) == 0) begin
            chk("unexpected_strobe", int'(en[d]), 0);
          end else begin
            e = qfront(d);
            chk("strobe_cycle", cyc, e.edge_n);
            if (e.edge_n == cyc) begin
              e = qpop(d);
              chk("d1", int'(o1[d]), e.d1);
              chk("d2", int'(o2[d]), e.d2);
              chk("d3", int'(o3[d]), e.d3);
              chk("sat", int'(st[d]), int'(e.sat));
              lst1[d] = e.d1; lst2[d] = e.d2; lst3[d] = e.d3;
            end
          end
        end else begin
          if (qsize(d) > 0 && qfront(d).edge_n <= cyc) begin
            chk("missed_strobe", int'(en[d]), 1);
            e = qpop(d);
          end
          chk("hold_d1", int'(o1[d]), lst1[d]);
          chk("hold_d2", int'(o2[d]), lst2[d]);
          chk("hold_d3", int'(o3[d]), lst3[d]);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_i[d] = 1'b1; clr[d] = 1'b0; vld[d] = 1'b0; dat[d] = '0;
      model_reset(d);
    end
    repeat (3) @(negedge clk);
    #1;
    rst_i[0] = 1'b0; rst_i[1] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      chk("reset_en", int'(en[d]), 0);
      chk("reset_d1", int'(o1[d]), 0);
      chk("reset_d2", int'(o2[d]), 0);
      chk("reset_d3", int'(o3[d]), 0);
      chk("reset_sat", int'(st[d]), 0);
    end
    mon_on = 1'b1;

    // constant input: first strobe after the 16th sample, all zeros
    for (int i = 0; i < 16; i++) step(0, 1'b1, 1000);
    idle(0, 4);

    // ramp: d1=40, d2=d3=0 once history is ramp-only
    flush(0, 1'b0, 1'b0, 0);
    for (int n = 0; n < 64; n++) step(0, 1'b1, 10 * n);
    idle(0, 4);

    // step: averages 0,0,0,0,100,100
    flush(0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 4; j++) step(0, 1'b1, (i < 4) ? 0 : 100);
    idle(0, 4);

    // alternating extremes -> saturation
    flush(0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 4; j++) step(0, 1'b1, (i % 2 == 1) ? 2047 : -2048);
    idle(0, 4);

    // clear mid-block, clear coincident with a sample, gapped refill
    flush(0, 1'b0, 1'b0, 0);
    step(0, 1'b1, 500);
    step(0, 1'b1, 500);
    flush(0, 1'b0, 1'b1, 777);
    for (int i = 0; i < 16; i++) begin
      step(0, 1'b1, 300 + i);
      if (i % 3 == 0) step(0, 1'b0, 0);
    end
    idle(0, 4);

    // randomized traffic with gaps and occasional clears
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(63, 0) == 0) flush(0, 1'b0, 1'(($urandom_range(1, 0))), rnd_sample());
      else step(0, ($urandom_range(3, 0) != 0), rnd_sample());
    end
    idle(0, 6);

    // unaveraged instance: ramp step 3 every cycle, rst mid-stream
    flush(1, 1'b1, 1'b0, 0);
    for (int n = 0; n < 50; n++) begin
      if (n == 25) flush(1, 1'b1, 1'b1, 3 * n);
      else step(1, 1'b1, 3 * n);
    end
    idle(1, 4);
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(63, 0) == 0) flush(1, 1'b0, 1'b1, rnd_sample());
      else step(1, ($urandom_range(7, 0) != 0), rnd_sample());
    end
    idle(1, 8);
    idle(0, 2);

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
